gemm_dispatch: RTL and testbench
================================

Name: gemm_dispatch

Overview:
- Instruction dispatcher and dependency-token scheduler that sequences the gemm core.
- Buffers 128-bit VTA instructions in a small FIFO and waits for the dependency tokens each instruction requests (pop_prev_dep / pop_next_dep).
- Drives the held instruction and a start pulse into gemm, waits for completion, then emits the requested tokens (push_prev_dep / push_next_dep).
- Sits between the instruction fetch/queue logic and gemm, and exchanges tokens with the load stage (prev) and the store stage (next).

Parameters:
INS_WIDTH, 128, instruction width; field layout as in the gemm instruction format
FIFO_DEPTH, 4, instruction FIFO entries (power of two, at least 2)
CNT_WIDTH, 4, width of each dependency-token counter (max 15 outstanding tokens)

Ports:
ap_clk  in  1  clock
ap_rst_n  in  1  synchronous reset, active-high (asserted = 1)
insn_in  in  INS_WIDTH  incoming instruction
insn_in_valid  in  1  insn_in valid
insn_in_ready  out  1  FIFO not full
prev_tok_in  in  1  one-cycle pulse = one token from the load stage
next_tok_in  in  1  one-cycle pulse = one token from the store stage
prev_tok_out  out  1  one-cycle pulse = one token to the load stage
next_tok_out  out  1  one-cycle pulse = one token to the store stage
gemm_insn  out  INS_WIDTH  instruction presented to gemm
gemm_start  out  1  one-cycle start pulse to gemm
gemm_done  in  1  one-cycle completion pulse from gemm
finish  out  1  one-cycle pulse on a FINISH instruction
busy  out  1  state != IDLE, or FIFO not empty
err  out  1  sticky error flag

Behaviour:
- Reset: every output is 0; FIFO empty; both token counters 0; state IDLE; err cleared. Reset mid-operation abandons the in-flight instruction, and no tokens or finish pulse are emitted.
- FIFO handshake:
  - Push when insn_in_valid && insn_in_ready.
  - insn_in_ready = !full.
  - The FSM pops the FIFO only in PUSH.
  - A simultaneous push and pop when full is not allowed, because ready is already low.
- Token counters prev_cnt and next_cnt:
  - Increment on the matching *_tok_in pulse.
  - Decrement by 1 in ISSUE when the held instruction has the matching pop bit set.
  - Increment and decrement in the same cycle leaves the count unchanged.
  - At max (2^CNT_WIDTH-1), an increment is dropped and err is set.
- FSM:
  - IDLE: if the FIFO is not empty, latch the head into gemm_insn -> WAIT_DEP.
  - WAIT_DEP: if (!insn[3] || prev_cnt != 0) && (!insn[4] || next_cnt != 0) -> ISSUE; otherwise stay.
  - ISSUE (1 cycle): decrement the requested counters.
    - opcode 2 (GEMM): gemm_start = 1 -> RUN.
    - opcode 3 (FINISH): finish = 1 -> PUSH.
    - Any other opcode: set err -> PUSH. The dependency bits are still honoured.
  - RUN: wait for gemm_done -> PUSH.
  - PUSH (1 cycle): prev_tok_out = insn[5], next_tok_out = insn[6]; pop the FIFO -> IDLE.
- gemm_insn is held stable from the WAIT_DEP entry until the next IDLE->WAIT_DEP latch.
- gemm_done outside RUN is ignored and sets err.
- Latency for a GEMM instruction with tokens already present:
  - Accept at cycle N; IDLE sees non-empty at N+1; WAIT_DEP at N+2; gemm_start high in cycle N+3.
  - gemm_done in cycle M gives PUSH in M+1, and the next instruction can reach WAIT_DEP at M+3.
- A token arriving in the same cycle that WAIT_DEP evaluates is counted next cycle; the check uses registered counts only.

Decomposition:
- Shared package gemm_pkg holds:
  - opcode constants: OP_LOAD=0, OP_STORE=1, OP_GEMM=2, OP_FINISH=3, OP_ALU=4;
  - instruction bit-position constants for opcode[2:0] and dependency bits [3]..[6];
  - the FSM state encoding.
- One sub-module, gemm_insn_fifo: a synchronous FIFO with parameters WIDTH and DEPTH, and ports push, pop, din, dout, full, empty. Its dout is first-word-fall-through.

Test Plan:
1. GEMM instruction, no dependency bits, accepted at cycle 10 -> gemm_start=1 at cycle 13 with gemm_insn equal to the input; gemm_done at 20 -> PUSH at 21 with no token pulses; busy=0 at 22.
2. GEMM with pop_prev_dep=1 and prev_cnt=0 -> stays in WAIT_DEP for 50 cycles; prev_tok_in pulse at cycle 60 -> gemm_start at 62; prev_cnt returns to 0.
3. GEMM with push_prev_dep=1 and push_next_dep=1 -> exactly one prev_tok_out and one next_tok_out pulse, both in the cycle after gemm_done.
4. Five back-to-back valid instructions with gemm_done withheld -> insn_in_ready=0 after 4 are accepted; the 5th is accepted the cycle after the first PUSH; all execute in order.
5. 16 prev_tok_in pulses with CNT_WIDTH=4 -> prev_cnt=15 and err=1; a FINISH instruction with pop_prev_dep=1 -> finish pulse and prev_cnt=14.
6. Reset asserted during RUN, followed by gemm_done -> no token pulses, FIFO empty, all outputs 0, err=0.

Source files
------------

// File: rtl/gemm_pkg.sv
// gemm_pkg
// Shared definitions for the gemm dispatcher:
//   - VTA opcode values carried in insn[2:0]
//   - bit positions of the opcode field and the four dependency-token flags
//   - the dispatcher FSM state encoding
// No ports; imported by the dispatcher RTL and its testbench.
package gemm_pkg;

  localparam logic [2:0] OP_LOAD   = 3'd0;
  localparam logic [2:0] OP_STORE  = 3'd1;
  localparam logic [2:0] OP_GEMM   = 3'd2;
  localparam logic [2:0] OP_FINISH = 3'd3;
  localparam logic [2:0] OP_ALU    = 3'd4;

  localparam int OP_LSB        = 0;
  localparam int OP_MSB        = 2;
  localparam int POP_PREV_BIT  = 3;
  localparam int POP_NEXT_BIT  = 4;
  localparam int PUSH_PREV_BIT = 5;
  localparam int PUSH_NEXT_BIT = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_DEP,
    ST_ISSUE,
    ST_RUN,
    ST_PUSH
  } state_e;

endpackage

// File: rtl/gemm_dispatch_if.sv
// gemm_dispatch_if
// Groups every non-clock/reset signal of the gemm dispatcher.
//   insn_in / insn_in_valid / insn_in_ready : instruction push handshake
//   prev_tok_in / next_tok_in               : token pulses from load / store stage
//   prev_tok_out / next_tok_out             : token pulses to load / store stage
//   gemm_insn / gemm_start / gemm_done      : command and completion to/from gemm
//   finish / busy / err                     : status
// Modports: master = environment driving the dispatcher, slave = dispatcher.
interface gemm_dispatch_if #(
  parameter int INS_WIDTH = 128
);

  logic [INS_WIDTH-1:0] insn_in;
  logic                 insn_in_valid;
  logic                 insn_in_ready;
  logic                 prev_tok_in;
  logic                 next_tok_in;
  logic                 prev_tok_out;
  logic                 next_tok_out;
  logic [INS_WIDTH-1:0] gemm_insn;
  logic                 gemm_start;
  logic                 gemm_done;
  logic                 finish;
  logic                 busy;
  logic                 err;

  modport master (
    output insn_in, insn_in_valid, prev_tok_in, next_tok_in, gemm_done,
    input  insn_in_ready, prev_tok_out, next_tok_out, gemm_insn, gemm_start,
           finish, busy, err
  );

  modport slave (
    input  insn_in, insn_in_valid, prev_tok_in, next_tok_in, gemm_done,
    output insn_in_ready, prev_tok_out, next_tok_out, gemm_insn, gemm_start,
           finish, busy, err
  );

endinterface

// File: rtl/gemm_insn_fifo.sv
// gemm_insn_fifo
// Synchronous first-word-fall-through FIFO holding pending instructions.
//   clk, rst : clock and synchronous active-high reset
//   push     : write din (ignored when full)
//   pop      : drop the head entry (ignored when empty)
//   din      : write data
//   dout     : current head entry, valid whenever empty is low
//   full     : no free entry
//   empty    : no stored entry
module gemm_insn_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wrPtr_q, wrPtr_d;
  logic [AW:0]      rdPtr_q, rdPtr_d;
  logic             doPush;
  logic             doPop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // when the index bits match.
  assign empty  = (wrPtr_q == rdPtr_q);
  assign full   = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                  (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign dout   = mem_q[rdPtr_q[AW-1:0]];

  // Next pointer values.
  always_comb begin
    wrPtr_d = wrPtr_q + {{AW{1'b0}}, doPush};
    rdPtr_d = rdPtr_q + {{AW{1'b0}}, doPop};
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wrPtr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/gemm_dispatch.sv
// gemm_dispatch
// Buffers VTA instructions, waits for the dependency tokens each one asks
// for, issues it to gemm (or handles FINISH / unsupported opcodes locally),
// then returns the tokens it was asked to push.
//   ap_clk   : clock
//   ap_rst_n : synchronous reset, active-high despite its name
//   bus      : gemm_dispatch_if.slave (instruction handshake, token pulses,
//              gemm command/completion, finish/busy/err status)
module gemm_dispatch
  import gemm_pkg::*;
#(
  parameter int INS_WIDTH  = 128,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 4
) (
  input  logic            ap_clk,
  input  logic            ap_rst_n,
  gemm_dispatch_if.slave  bus
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_e                 state_q, state_d;
  logic [INS_WIDTH-1:0]   insn_q, insn_d;
  logic [CNT_WIDTH-1:0]   prevCnt_q, prevCnt_d;
  logic [CNT_WIDTH-1:0]   nextCnt_q, nextCnt_d;
  logic                   err_q, err_d;

  logic [INS_WIDTH-1:0]   fifoDout;
  logic                   fifoFull;
  logic                   fifoEmpty;
  logic                   fifoPush;
  logic                   fifoPop;

  logic [2:0]             opcode;
  logic                   depsReady;
  logic                   prevDec, nextDec;
  logic                   prevOvf, nextOvf;
  logic                   illegalOp;
  logic                   startC, finishC, prevOutC, nextOutC;

  // Saturating up/down step; returns {overflow, next count}. A token arriving
  // in the same cycle as a consume cancels out.
  function automatic logic [CNT_WIDTH:0] stepCount(
    input logic [CNT_WIDTH-1:0] cnt,
    input logic                 inc,
    input logic                 dec
  );
    logic [CNT_WIDTH-1:0] nxt;
    logic                 ovf;
    nxt = cnt;
    ovf = 1'b0;
    if (inc && !dec) begin
      if (cnt == CNT_MAX) begin
        ovf = 1'b1;
      end else begin
        nxt = cnt + CNT_ONE;
      end
    end else if (dec && !inc) begin
      nxt = cnt - CNT_ONE;
    end
    return {ovf, nxt};
  endfunction

  // Reset gates the handshake so nothing is accepted while it is held.
  assign fifoPush = bus.insn_in_valid && bus.insn_in_ready;

  gemm_insn_fifo #(
    .WIDTH (INS_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) uInsnFifo (
    .clk   (ap_clk),
    .rst   (ap_rst_n),
    .push  (fifoPush),
    .pop   (fifoPop),
    .din   (bus.insn_in),
    .dout  (fifoDout),
    .full  (fifoFull),
    .empty (fifoEmpty)
  );

  assign opcode    = insn_q[OP_MSB:OP_LSB];
  assign depsReady = (!insn_q[POP_PREV_BIT] || (prevCnt_q != '0)) &&
                     (!insn_q[POP_NEXT_BIT] || (nextCnt_q != '0));

  // Sequencing FSM. The head entry stays in the FIFO while it executes and
  // is only popped in PUSH, so FIFO occupancy includes the in-flight one.
  always_comb begin
    state_d   = state_q;
    insn_d    = insn_q;
    fifoPop   = 1'b0;
    prevDec   = 1'b0;
    nextDec   = 1'b0;
    illegalOp = 1'b0;
    startC    = 1'b0;
    finishC   = 1'b0;
    prevOutC  = 1'b0;
    nextOutC  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifoEmpty) begin
          insn_d  = fifoDout;
          state_d = ST_WAIT_DEP;
        end
      end
      ST_WAIT_DEP: begin
        if (depsReady) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        prevDec = insn_q[POP_PREV_BIT];
        nextDec = insn_q[POP_NEXT_BIT];
        case (opcode)
          OP_GEMM: begin
            startC  = 1'b1;
            state_d = ST_RUN;
          end
          OP_FINISH: begin
            finishC = 1'b1;
            state_d = ST_PUSH;
          end
          default: begin
            illegalOp = 1'b1;
            state_d   = ST_PUSH;
          end
        endcase
      end
      ST_RUN: begin
        if (bus.gemm_done) begin
          state_d = ST_PUSH;
        end
      end
      ST_PUSH: begin
        prevOutC = insn_q[PUSH_PREV_BIT];
        nextOutC = insn_q[PUSH_NEXT_BIT];
        fifoPop  = 1'b1;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Token counters and the sticky error flag.
  always_comb begin
    {prevOvf, prevCnt_d} = stepCount(prevCnt_q, bus.prev_tok_in, prevDec);
    {nextOvf, nextCnt_d} = stepCount(nextCnt_q, bus.next_tok_in, nextDec);
    err_d = err_q | prevOvf | nextOvf | illegalOp |
            (bus.gemm_done && (state_q != ST_RUN));
  end

  // State registers; reset abandons any in-flight instruction.
  always_ff @(posedge ap_clk) begin
    if (ap_rst_n) begin
      state_q   <= ST_IDLE;
      insn_q    <= '0;
      prevCnt_q <= '0;
      nextCnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      insn_q    <= insn_d;
      prevCnt_q <= prevCnt_d;
      nextCnt_q <= nextCnt_d;
      err_q     <= err_d;
    end
  end

  // Outputs are forced low while reset is held so the cycle in which reset
  // lands emits no token, start or finish pulse.
  assign bus.insn_in_ready = !ap_rst_n && !fifoFull;
  assign bus.gemm_insn     = ap_rst_n ? '0 : insn_q;
  assign bus.gemm_start    = !ap_rst_n && startC;
  assign bus.finish        = !ap_rst_n && finishC;
  assign bus.prev_tok_out  = !ap_rst_n && prevOutC;
  assign bus.next_tok_out  = !ap_rst_n && nextOutC;
  assign bus.busy          = !ap_rst_n && ((state_q != ST_IDLE) || !fifoEmpty);
  assign bus.err           = !ap_rst_n && err_q;

endmodule

// File: tb/tb_gemm_dispatch.sv
// tb_gemm_dispatch
// Self-checking bench for gemm_dispatch: a table of single-instruction
// vectors plus hand-written sequences for stalls, FIFO back-pressure,
// counter saturation and reset during RUN. Issued instructions are checked
// against a scoreboard queue filled when stimulus is driven.
module tb_gemm_dispatch;
  import gemm_pkg::*;

  localparam int INS_W = 128;

  typedef struct {
    logic [INS_W-1:0] insn;
    int               preP;
    int               preN;
    bit               expStart;
    bit               expFinish;
    bit               expPrevOut;
    bit               expNextOut;
    bit               expErr;
    int               expPrevCnt;
    int               expNextCnt;
  } vec_t;

  logic ap_clk   = 1'b0;
  logic ap_rst_n = 1'b1;

  gemm_dispatch_if #(.INS_WIDTH(INS_W)) bus();

  gemm_dispatch #(
    .INS_WIDTH  (INS_W),
    .FIFO_DEPTH (4),
    .CNT_WIDTH  (4)
  ) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus)
  );

  always #5 ap_clk = ~ap_clk;

  int cyc = 0;
  always @(posedge ap_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [INS_W-1:0] sbQ[$];
  int startCount  = 0;
  int finishCount = 0;
  int totPrevOut  = 0;
  int totNextOut  = 0;

  int obsStart, obsDone, obsFinish, obsPrevCyc, obsNextCyc;
  int obsPrevN, obsNextN, obsIdle, accCyc;

  vec_t vecs[8];
  logic [INS_W-1:0] pays[5];

  function automatic logic [INS_W-1:0] mkInsn(input logic [2:0] op,
                                               input bit popP, input bit popN,
                                               input bit pushP, input bit pushN,
                                               input logic [31:0] tag);
    return {tag, 57'd0, tag, pushN, pushP, popN, popP, op};
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Scoreboard: every start/finish pulse must match the oldest queued insn.
  always @(negedge ap_clk) begin
    logic [INS_W-1:0] expInsn;
    if (bus.gemm_start || bus.finish) begin
      if (bus.gemm_start) startCount++;
      if (bus.finish) finishCount++;
      checkOutput("sbQueueDepth", sbQ.size() > 0, 1);
      if (sbQ.size() > 0) begin
        expInsn = sbQ.pop_front();
        checkOutput("sbInsn", bus.gemm_insn, expInsn);
        checkOutput("sbKind", bus.gemm_start, expInsn[2:0] == OP_GEMM);
      end
    end
    if (bus.prev_tok_out) totPrevOut++;
    if (bus.next_tok_out) totNextOut++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time %0t exceeded limit", $time);
    $fatal(1, "[TB] watchdog");
  end

  task automatic applyReset();
    @(negedge ap_clk);
    ap_rst_n          = 1'b1;
    bus.insn_in       = '0;
    bus.insn_in_valid = 1'b0;
    bus.prev_tok_in   = 1'b0;
    bus.next_tok_in   = 1'b0;
    bus.gemm_done     = 1'b0;
    sbQ.delete();
    repeat (2) @(negedge ap_clk);
    checkOutput("rstOutputs",
                {bus.insn_in_ready, bus.gemm_start, bus.finish, bus.prev_tok_out,
                 bus.next_tok_out, bus.busy, bus.err}, 7'd0);
    checkOutput("rstInsn", bus.gemm_insn, '0);
    ap_rst_n = 1'b0;
    @(negedge ap_clk);
    checkOutput("postRstState", {bus.insn_in_ready, bus.busy, bus.err}, 3'b100);
  endtask

  task automatic applyStimulus(input logic [INS_W-1:0] insn, input bit track);
    @(negedge ap_clk);
    bus.prev_tok_in = 1'b0;
    bus.next_tok_in = 1'b0;
    checkOutput("stimReady", bus.insn_in_ready, 1);
    bus.insn_in       = insn;
    bus.insn_in_valid = 1'b1;
    accCyc            = cyc;
    if (track) sbQ.push_back(insn);
  endtask

  // Runs until busy drops, answering each gemm_start with gemm_done three
  // cycles later and recording when each output pulse was seen.
  task automatic runToIdle(input int bound);
    int pendDone;
    pendDone   = -1;
    obsStart   = -1;
    obsDone    = -1;
    obsFinish  = -1;
    obsPrevCyc = -1;
    obsNextCyc = -1;
    obsPrevN   = 0;
    obsNextN   = 0;
    obsIdle    = -1;
    for (int k = 0; k < bound && obsIdle < 0; k++) begin
      @(negedge ap_clk);
      bus.insn_in_valid = 1'b0;
      bus.prev_tok_in   = 1'b0;
      bus.next_tok_in   = 1'b0;
      bus.gemm_done     = 1'b0;
      if (bus.gemm_start) begin
        obsStart = cyc;
        pendDone = cyc + 3;
      end
      if (cyc == pendDone) begin
        bus.gemm_done = 1'b1;
        obsDone       = cyc;
      end
      if (bus.finish) obsFinish = cyc;
      if (bus.prev_tok_out) begin
        obsPrevN++;
        obsPrevCyc = cyc;
      end
      if (bus.next_tok_out) begin
        obsNextN++;
        obsNextCyc = cyc;
      end
      if (!bus.busy) obsIdle = cyc;
    end
    checkOutput("idleReached", obsIdle >= 0, 1);
  endtask

  initial begin
    int pushCyc;
    int tokCyc;
    int startBase;
    int prevBase;
    int nextBase;
    bit startSeen;

    bus.insn_in       = '0;
    bus.insn_in_valid = 1'b0;
    bus.prev_tok_in   = 1'b0;
    bus.next_tok_in   = 1'b0;
    bus.gemm_done     = 1'b0;

    //            insn                                                   preP preN start fin pOut nOut err pCnt nCnt
    vecs[0] = '{mkInsn(OP_GEMM,   0, 0, 0, 0, 32'h1111_0000),            0,  0,  1, 0, 0, 0, 0, 0, 0};
    vecs[1] = '{mkInsn(OP_GEMM,   1, 1, 1, 1, 32'h2222_0001),            1,  1,  1, 0, 1, 1, 0, 0, 0};
    vecs[2] = '{mkInsn(OP_FINISH, 0, 0, 0, 1, 32'h3333_0002),            0,  0,  0, 1, 0, 1, 0, 0, 0};
    vecs[3] = '{mkInsn(OP_ALU,    0, 0, 1, 0, 32'h4444_0003),            0,  0,  0, 0, 1, 0, 1, 0, 0};
    vecs[4] = '{mkInsn(OP_LOAD,   0, 1, 0, 0, 32'h5555_0004),            0,  2,  0, 0, 0, 0, 1, 0, 1};
    vecs[5] = '{mkInsn(OP_GEMM,   0, 0, 1, 0, 32'h6666_0005),            1,  0,  1, 0, 1, 0, 0, 1, 0};
    vecs[6] = '{mkInsn(OP_STORE,  1, 1, 0, 1, 32'h7777_0006),            3,  1,  0, 0, 0, 1, 1, 2, 0};
    vecs[7] = '{mkInsn(OP_GEMM,   0, 1, 0, 0, 32'h8888_0007),            0, 15,  1, 0, 0, 0, 0, 0, 14};

    for (int i = 0; i < 8; i++) begin
      applyReset();
      for (int k = 0; k < vecs[i].preP || k < vecs[i].preN; k++) begin
        @(negedge ap_clk);
        bus.prev_tok_in = (k < vecs[i].preP);
        bus.next_tok_in = (k < vecs[i].preN);
      end
      applyStimulus(vecs[i].insn, vecs[i].expStart || vecs[i].expFinish);
      runToIdle(60);
      pushCyc = vecs[i].expStart ? accCyc + 7 : accCyc + 4;
      checkOutput($sformatf("v%0d_startCyc", i), obsStart,
                  vecs[i].expStart ? accCyc + 3 : -1);
      checkOutput($sformatf("v%0d_finishCyc", i), obsFinish,
                  vecs[i].expFinish ? accCyc + 3 : -1);
      checkOutput($sformatf("v%0d_prevOutN", i), obsPrevN, vecs[i].expPrevOut);
      checkOutput($sformatf("v%0d_nextOutN", i), obsNextN, vecs[i].expNextOut);
      checkOutput($sformatf("v%0d_prevOutCyc", i), obsPrevCyc,
                  vecs[i].expPrevOut ? pushCyc : -1);
      checkOutput($sformatf("v%0d_nextOutCyc", i), obsNextCyc,
                  vecs[i].expNextOut ? pushCyc : -1);
      checkOutput($sformatf("v%0d_idleCyc", i), obsIdle, pushCyc + 1);
      checkOutput($sformatf("v%0d_err", i), bus.err, vecs[i].expErr);
      checkOutput($sformatf("v%0d_prevCnt", i), dut.prevCnt_q, vecs[i].expPrevCnt);
      checkOutput($sformatf("v%0d_nextCnt", i), dut.nextCnt_q, vecs[i].expNextCnt);
    end

    // Stall in WAIT_DEP until a prev token arrives.
    applyReset();
    startBase = startCount;
    applyStimulus(mkInsn(OP_GEMM, 1, 0, 0, 0, 32'h9999_0010), 1);
    repeat (50) begin
      @(negedge ap_clk);
      bus.insn_in_valid = 1'b0;
    end
    checkOutput("stallNoStart", startCount - startBase, 0);
    checkOutput("stallBusy", bus.busy, 1);
    bus.prev_tok_in = 1'b1;
    tokCyc          = cyc;
    runToIdle(40);
    checkOutput("stallStartCyc", obsStart, tokCyc + 2);
    checkOutput("stallPrevCnt", dut.prevCnt_q, 0);

    // Back-pressure: five instructions, first gemm_done withheld.
    applyReset();
    startBase = startCount;
    for (int k = 0; k < 5; k++) pays[k] = mkInsn(OP_GEMM, 0, 0, 0, 0, 32'hA000_0000 + k);
    for (int k = 0; k <= 11; k++) begin
      @(negedge ap_clk);
      bus.gemm_done = 1'b0;
      if (k < 4) checkOutput($sformatf("bpReadyFree%0d", k), bus.insn_in_ready, 1);
      if (k <= 4) begin
        bus.insn_in       = pays[k];
        bus.insn_in_valid = 1'b1;
        sbQ.push_back(pays[k]);
      end
      if (k == 4) checkOutput("bpReadyFull", bus.insn_in_ready, 0);
      if (k == 8) bus.gemm_done = 1'b1;
      if (k == 9) checkOutput("bpReadyAtPush", bus.insn_in_ready, 0);
      if (k == 10) checkOutput("bpReadyAfterPush", bus.insn_in_ready, 1);
      if (k == 11) bus.insn_in_valid = 1'b0;
    end
    runToIdle(200);
    checkOutput("bpStartCount", startCount - startBase, 5);
    checkOutput("bpQueueDrained", sbQ.size(), 0);
    checkOutput("bpErr", bus.err, 0);

    // Counter saturation, then FINISH consuming one prev token.
    applyReset();
    for (int k = 0; k < 16; k++) begin
      @(negedge ap_clk);
      if (k == 15) begin
        checkOutput("satCnt15", dut.prevCnt_q, 15);
        checkOutput("satErrBefore", bus.err, 0);
      end
      bus.prev_tok_in = 1'b1;
    end
    @(negedge ap_clk);
    bus.prev_tok_in = 1'b0;
    checkOutput("satCntHeld", dut.prevCnt_q, 15);
    checkOutput("satErrSet", bus.err, 1);
    applyStimulus(mkInsn(OP_FINISH, 1, 0, 0, 0, 32'hB000_0020), 1);
    runToIdle(40);
    checkOutput("satFinishCyc", obsFinish, accCyc + 3);
    checkOutput("satCnt14", dut.prevCnt_q, 14);
    checkOutput("satErrSticky", bus.err, 1);

    // Reset during RUN with a coincident gemm_done.
    applyReset();
    applyStimulus(mkInsn(OP_GEMM, 0, 0, 1, 1, 32'hC000_0030), 1);
    startSeen = 1'b0;
    for (int k = 0; k < 10 && !startSeen; k++) begin
      @(negedge ap_clk);
      bus.insn_in_valid = 1'b0;
      if (bus.gemm_start) startSeen = 1'b1;
    end
    checkOutput("rrStartSeen", startSeen, 1);
    @(negedge ap_clk);
    prevBase = totPrevOut;
    nextBase = totNextOut;
    @(negedge ap_clk);
    ap_rst_n      = 1'b1;
    bus.gemm_done = 1'b1;
    @(negedge ap_clk);
    bus.gemm_done = 1'b0;
    @(negedge ap_clk);
    ap_rst_n = 1'b0;
    repeat (4) @(negedge ap_clk);
    checkOutput("rrNoPrevTok", totPrevOut - prevBase, 0);
    checkOutput("rrNoNextTok", totNextOut - nextBase, 0);
    checkOutput("rrStatus",
                {bus.insn_in_ready, bus.busy, bus.err, bus.gemm_start, bus.finish},
                5'b10000);
    checkOutput("rrInsn", bus.gemm_insn, '0);

    // gemm_done outside RUN is an error.
    bus.gemm_done = 1'b1;
    @(negedge ap_clk);
    bus.gemm_done = 1'b0;
    checkOutput("strayDoneErr", bus.err, 1);
    checkOutput("strayDoneBusy", bus.busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
